// File: rtl/serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl
//
// Bit-serial WIDTH-bit adder. A single full-adder cell, built from two
// half_adder instances and an OR for the carry, is reused for every operand
// bit. Operands are shifted through the cell LSB-first. The result appears
// WIDTH+1 cycles after a request is accepted, and a one-cycle done pulse
// marks it.
//
// Ports
//   clk_i        rising-edge clock
//   rst_i        synchronous, active-high reset
//   start_i      request; honoured only when no operation is in flight
//   a_i, b_i     operands, captured on the accepting edge
//   sub_i        subtract select (only with SERIAL_ADDER_SUB_EN)
//   busy_o       high while operand bits are being processed
//   done_o       one-cycle pulse when sum_o/carry_out_o update
//   sum_o        registered result, held until the next completion
//   carry_out_o  final carry (add) / not-borrow (subtract)
//
// Build option
//   SERIAL_ADDER_SUB_EN  adds sub_i. With sub_i=1, B is inverted and the carry
//                        starts at 1, which gives a - b mod 2^WIDTH.
// -----------------------------------------------------------------------------

module half_adder (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i;
  assign c_o = a_i & b_i;
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub_i,
`endif
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_out_o
);

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADD,
    ST_DONE
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_sr_q, b_sr_q, res_q;
  logic [WIDTH-1:0] a_sr_d, b_sr_d, res_d;
  logic             c_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, done_q, cout_q;
  logic [WIDTH-1:0] sum_q;

  // Operand B and the initial carry as they are loaded on acceptance
  logic [WIDTH-1:0] b_init_d;
  logic             c_init_d;

  always_comb begin
    b_init_d = b_i;
    c_init_d = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    // Two's-complement subtract: a + ~b + 1
    if (sub_i) begin
      b_init_d = ~b_i;
      c_init_d = 1'b1;
    end
`endif
  end

  // Shared full-adder cell
  logic ha0_s, ha0_c, ha1_s, ha1_c, c_next;

  half_adder u_ha0 (
    .a_i (a_sr_q[0]),
    .b_i (b_sr_q[0]),
    .s_o (ha0_s),
    .c_o (ha0_c)
  );

  half_adder u_ha1 (
    .a_i (ha0_s),
    .b_i (c_q),
    .s_o (ha1_s),
    .c_o (ha1_c)
  );

  assign c_next = ha0_c | ha1_c;

  always_comb begin
    a_sr_d = a_sr_q >> 1;
    b_sr_d = b_sr_q >> 1;
    // Sum bits enter at the MSB, so after WIDTH shifts bit 0 is the first bit
    res_d  = {ha1_s, res_q[WIDTH-1:1]};
    cnt_d  = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      res_q   <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      case (state_q)
        // DONE samples start just like IDLE. A held request therefore
        // sustains one operation every WIDTH+1 cycles.
        ST_IDLE, ST_DONE: begin
          done_q <= 1'b0;
          if (start_i) begin
            a_sr_q  <= a_i;
            b_sr_q  <= b_init_d;
            c_q     <= c_init_d;
            res_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_ADD;
          end else begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end

        ST_ADD: begin
          a_sr_q <= a_sr_d;
          b_sr_q <= b_sr_d;
          res_q  <= res_d;
          c_q    <= c_next;
          if (cnt_q == LAST) begin
            sum_q   <= res_d;
            cout_q  <= c_next;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            cnt_q   <= cnt_d;
          end
        end

        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign sum_o       = sum_q;
  assign carry_out_o = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_adder_ctrl
//
// Directed bench for serial_adder_ctrl with WIDTH=8. Expected values are
// computed by hand. When SERIAL_ADDER_SUB_EN is defined, the subtract vectors
// also run.
// -----------------------------------------------------------------------------

module tb_serial_adder_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a, b;
  logic       sub;
  logic       busy, done, cout;
  logic [7:0] sum;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int fail_cnt  = 0;

  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .a_i         (a),
    .b_i         (b),
`ifdef SERIAL_ADDER_SUB_EN
    .sub_i       (sub),
`endif
    .busy_o      (busy),
    .done_o      (done),
    .sum_o       (sum),
    .carry_out_o (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle. Returns the cycle (counted in
  // negedges after the accepting edge) in which done was seen, the number of
  // busy cycles, and whether sum/carry held their old values until done.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic ts,
                        output int lat, output int busy_cnt, output int held);
    logic [7:0] prev_sum;
    logic       prev_c;
    prev_sum = sum;
    prev_c   = cout;
    a = ta; b = tb_v; sub = ts; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = ~ta; b = ~tb_v; sub = ~ts;
    lat = 0; busy_cnt = 0; held = 1;
    do begin
      @(negedge clk);
      lat++;
      if (busy) busy_cnt++;
      if (!done && (sum !== prev_sum || cout !== prev_c)) held = 0;
    end while (!done && lat < 20);
  endtask

  initial begin
    int lat, bc, held, n, nd, nb, t1, t2;

    rst = 1'b1; start = 1'b0; a = '0; b = '0; sub = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum",  sum,  0);
    chk("rst_cout", cout, 0);
    rst = 1'b0;

    // Basic add
    run_op(8'h12, 8'h34, 1'b0, lat, bc, held);
    chk("add_lat",  lat,  9);
    chk("add_busy", bc,   8);
    chk("add_held", held, 1);
    chk("add_sum",  sum,  8'h46);
    chk("add_cout", cout, 0);
    @(negedge clk);
    chk("done_width", done, 0);

    // Wrap / carry
    run_op(8'hFF, 8'h01, 1'b0, lat, bc, held);
    chk("wrap_lat",  lat,  9);
    chk("wrap_sum",  sum,  8'h00);
    chk("wrap_cout", cout, 1);
    @(negedge clk);
    run_op(8'hFF, 8'hFF, 1'b0, lat, bc, held);
    chk("ffff_held", held, 1);
    chk("ffff_sum",  sum,  8'hFE);
    chk("ffff_cout", cout, 1);
    @(negedge clk);

    // Start re-asserted during ADD is ignored
    a = 8'h20; b = 8'h22; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    start = 1'b1; a = 8'h01; b = 8'h01;
    @(negedge clk);
    start = 1'b0;
    n = 4;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ign_lat",  n,    9);
    chk("ign_sum",  sum,  8'h42);
    chk("ign_cout", cout, 0);
    nd = 0; nb = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) nd++;
      if (busy) nb++;
    end
    chk("ign_no_done", nd, 0);
    chk("ign_no_busy", nb, 0);

    // Reset in the middle of ADD
    a = 8'h55; b = 8'h0F; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_sum",  sum,  0);
    chk("mid_rst_cout", cout, 0);
    rst = 1'b0;
    nd = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("mid_rst_no_done", nd, 0);

    // Back-to-back with start held high
    a = 8'h0A; b = 8'h05; start = 1'b1;
    @(posedge clk);
    #1;
    a = 8'h80; b = 8'h80;
    n = 0; t1 = -1; t2 = -1;
    while (t2 < 0 && n < 30) begin
      @(negedge clk);
      n++;
      if (done) begin
        if (t1 < 0) begin
          t1 = n;
          chk("b2b_sum1",  sum,  8'h0F);
          chk("b2b_cout1", cout, 0);
        end else begin
          t2 = n;
          chk("b2b_sum2",  sum,  8'h00);
          chk("b2b_cout2", cout, 1);
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    chk("b2b_t1",  t1,      9);
    chk("b2b_gap", t2 - t1, 9);
    nd = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("b2b_no_third", nd, 0);

`ifdef SERIAL_ADDER_SUB_EN
    run_op(8'h10, 8'h01, 1'b1, lat, bc, held);
    chk("sub1_lat",  lat,  9);
    chk("sub1_sum",  sum,  8'h0F);
    chk("sub1_cout", cout, 1);
    @(negedge clk);
    run_op(8'h01, 8'h02, 1'b1, lat, bc, held);
    chk("sub2_sum",  sum,  8'hFF);
    chk("sub2_cout", cout, 0);
    @(negedge clk);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
